mem_arbiter: RTL and testbench

- Shares the single-ported main RAM between the instruction-fetch request path and the memory-stage data request path.
- Data requests (dREN/dWEN from the memory stage) have priority, so the memory stage drains before fetch.
- Holds one grant at a time until the RAM reports ACCESS, then returns the hit/load to the owner.
- Sits between the pipeline caches and the RAM model.

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported main RAM between instruction fetch and memory-stage data requests.
// Data requests have priority; define MEM_ARB_FAIRNESS_EN to bound data streaks while a fetch waits.
module mem_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned SCNT_W      = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);

  typedef enum logic [1:0] {StIdle, StDGnt, StIGnt} stateT;

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  if (2 ** SCNT_W <= MAX_DSTREAK) begin : gBadStreakWidth
    $error("SCNT_W too narrow to hold MAX_DSTREAK");
  end

  stateT stateQ, stateD;
  logic  dReq;
  logic  ramDone;
  logic  fetchTurn;

  assign dReq    = dREN | dWEN;
  assign ramDone = (ramstate == RamAccess) || (ramstate == RamError);

`ifdef MEM_ARB_FAIRNESS_EN
  logic [SCNT_W-1:0] streakQ, streakD;

  assign fetchTurn = iREN && (streakQ == SCNT_W'(MAX_DSTREAK));

  always_comb begin
    streakD = streakQ;
    if (!iREN) begin
      streakD = '0;
    end else if (stateQ == StIdle && stateD == StIGnt) begin
      streakD = '0;
    end else if (stateQ == StIdle && stateD == StDGnt && streakQ != SCNT_W'(MAX_DSTREAK)) begin
      streakD = streakQ + SCNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      streakQ <= '0;
    end else begin
      streakQ <= streakD;
    end
  end
`else
  assign fetchTurn = 1'b0;
`endif

  // Every grant returns through StIdle, so a request still high at completion is not re-issued.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (dReq && !fetchTurn) begin
          stateD = StDGnt;
        end else if (iREN) begin
          stateD = StIGnt;
        end
      end
      StDGnt:  if (ramDone || !dReq) stateD = StIdle;
      StIGnt:  if (ramDone || !iREN) stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    ihit     = 1'b0;
    iload    = '0;
    dhit     = 1'b0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    merr     = 1'b0;
    unique case (stateQ)
      StDGnt: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        dhit     = (ramstate == RamAccess);
        merr     = (ramstate == RamError);
      end
      StIGnt: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        iload   = ramload;
        ihit    = (ramstate == RamAccess);
        merr    = (ramstate == RamError);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter; fairness expectations follow MEM_ARB_FAIRNESS_EN.
module tb_mem_arbiter;

  localparam logic [1:0] F = 2'd0;
  localparam logic [1:0] B = 2'd1;
  localparam logic [1:0] A = 2'd2;
  localparam logic [1:0] E = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ihit, dhit, ramREN, ramWEN, merr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int assertions = 0;
  int failures   = 0;

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .ihit    (ihit),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dhit    (dhit),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .merr    (merr)
  );

  typedef struct {
    string       name;
    logic        rst, iR, dR, dW;
    logic [31:0] ia, da, ds, rl;
    logic [1:0]  rs;
    logic [132:0] exp;  // {ihit,dhit,ramREN,ramWEN,merr,iload,dload,ramaddr,ramstore}
  } vecT;

  vecT vecs[$];

  task automatic addV(input string name, input logic rst, input logic iR, input logic [31:0] ia,
                      input logic dR, input logic dW, input logic [31:0] da, input logic [31:0] ds,
                      input logic [1:0] rs, input logic [31:0] rl,
                      input logic eih, input logic edh, input logic err, input logic erw,
                      input logic eme, input logic [31:0] eil, input logic [31:0] edl,
                      input logic [31:0] era, input logic [31:0] ers);
    vecT v;
    v.name = name; v.rst = rst; v.iR = iR; v.ia = ia; v.dR = dR; v.dW = dW;
    v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
    v.exp = {eih, edh, err, erw, eme, eil, edl, era, ers};
    vecs.push_back(v);
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic driveIdle();
    iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
    ramstate = F; ramload = 0;
  endtask

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int ExpDHits   = 8;
  localparam int ExpIHits   = 2;
  localparam logic [31:0] ExpFifth = 32'h600;
`else
  localparam int ExpDHits   = 10;
  localparam int ExpIHits   = 0;
  localparam logic [31:0] ExpFifth = 32'h500;
`endif

  initial begin
    logic [132:0] got;
    int dCnt, iCnt, grants;
    logic [31:0] fifthAddr;

    //    name          rst iR iaddr   dR dW daddr   dstore        rs rload
    //                  ih dh rR rW me  iload         dload         ramaddr  ramstore
    addV("rst_hold",    0, 0, 0,      1, 0, 'h100, 0,           F, 0,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);
    addV("rd_req",      1, 0, 0,      1, 0, 'h100, 0,           F, 0,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);
    addV("rd_busy1",    1, 0, 0,      1, 0, 'h100, 0,           B, 0,
                        0, 0, 1, 0, 0, 0,            0,            'h100,   0);
    addV("rd_busy2",    1, 0, 0,      1, 0, 'h100, 0,           B, 0,
                        0, 0, 1, 0, 0, 0,            0,            'h100,   0);
    addV("rd_access",   1, 0, 0,      1, 0, 'h100, 0,           A, 'hDEADBEEF,
                        0, 1, 1, 0, 0, 0,            'hDEADBEEF,   'h100,   0);
    addV("rd_idle",     1, 0, 0,      1, 0, 'h100, 0,           F, 0,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);
    addV("d_abort",     1, 0, 0,      0, 0, 0,     0,           F, 0,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);
    addV("sim_req",     1, 1, 0,      0, 1, 'h200, 'h12345678,  F, 0,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);
    addV("sim_dbusy",   1, 1, 0,      0, 1, 'h200, 'h12345678,  B, 0,
                        0, 0, 0, 1, 0, 0,            0,            'h200,   'h12345678);
    addV("sim_dacc",    1, 1, 0,      0, 1, 'h200, 'h12345678,  A, 0,
                        0, 1, 0, 1, 0, 0,            0,            'h200,   'h12345678);
    addV("sim_gap",     1, 1, 0,      0, 0, 0,     0,           F, 0,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);
    addV("sim_ibusy",   1, 1, 0,      0, 0, 0,     0,           B, 0,
                        0, 0, 1, 0, 0, 0,            0,            0,       0);
    addV("sim_iacc",    1, 1, 0,      0, 0, 0,     0,           A, 'hCAFEF00D,
                        1, 0, 1, 0, 0, 'hCAFEF00D,   0,            0,       0);
    addV("sim_idle",    1, 0, 0,      0, 0, 0,     0,           F, 0,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);
    addV("ab_req",      1, 1, 'h40,   0, 0, 0,     0,           F, 0,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);
    addV("ab_busy",     1, 1, 'h40,   0, 0, 0,     0,           B, 0,
                        0, 0, 1, 0, 0, 0,            0,            'h40,    0);
    addV("ab_drop",     1, 0, 'h40,   0, 0, 0,     0,           B, 0,
                        0, 0, 1, 0, 0, 0,            0,            'h40,    0);
    addV("ab_idle",     1, 0, 'h40,   0, 0, 0,     0,           A, 'h55,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);
    addV("er_req",      1, 0, 0,      1, 0, 'h300, 0,           F, 0,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);
    addV("er_err",      1, 0, 0,      1, 0, 'h300, 0,           E, 0,
                        0, 0, 1, 0, 1, 0,            0,            'h300,   0);
    addV("er_idle",     1, 0, 0,      0, 0, 0,     0,           E, 0,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);
    addV("rw_req",      1, 0, 0,      1, 1, 'h400, 'hA5A5A5A5,  F, 0,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);
    addV("rw_free",     1, 0, 0,      1, 1, 'h400, 'hA5A5A5A5,  F, 0,
                        0, 0, 0, 1, 0, 0,            0,            'h400,   'hA5A5A5A5);
    addV("rw_busy",     1, 0, 0,      1, 1, 'h400, 'hA5A5A5A5,  B, 0,
                        0, 0, 0, 1, 0, 0,            0,            'h400,   'hA5A5A5A5);
    addV("rs_assert",   0, 0, 0,      1, 1, 'h400, 'hA5A5A5A5,  B, 0,
                        0, 0, 0, 1, 0, 0,            0,            'h400,   'hA5A5A5A5);
    addV("rs_idle",     1, 0, 0,      1, 1, 'h400, 'hA5A5A5A5,  A, 'h99,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);
    addV("rs_regrant",  1, 0, 0,      1, 1, 'h400, 'hA5A5A5A5,  B, 0,
                        0, 0, 0, 1, 0, 0,            0,            'h400,   'hA5A5A5A5);
    addV("rs_acc",      1, 0, 0,      1, 1, 'h400, 'hA5A5A5A5,  A, 0,
                        0, 1, 0, 1, 0, 0,            0,            'h400,   'hA5A5A5A5);
    addV("end_idle",    1, 0, 0,      0, 0, 0,     0,           F, 0,
                        0, 0, 0, 0, 0, 0,            0,            0,       0);

    nRST = 0;
    driveIdle();
    repeat (2) @(posedge CLK);

    foreach (vecs[k]) begin
      @(negedge CLK);
      nRST = vecs[k].rst; iREN = vecs[k].iR; iaddr = vecs[k].ia;
      dREN = vecs[k].dR; dWEN = vecs[k].dW; daddr = vecs[k].da; dstore = vecs[k].ds;
      ramstate = vecs[k].rs; ramload = vecs[k].rl;
      #2;
      got = {ihit, dhit, ramREN, ramWEN, merr, iload, dload, ramaddr, ramstore};
      assertions++;
      if (got !== vecs[k].exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", vecs[k].name, got, vecs[k].exp);
      end
    end

    // Continuous data and fetch requests against a RAM that completes every access at once.
    @(negedge CLK);
    nRST = 0;
    driveIdle();
    @(negedge CLK);
    nRST = 1; iREN = 1; iaddr = 'h600; dREN = 1; daddr = 'h500; ramstate = A;
    dCnt = 0; iCnt = 0; grants = 0; fifthAddr = 0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (dhit) dCnt++;
      if (ihit) iCnt++;
      if (ramREN) begin
        grants++;
        if (grants == 5) fifthAddr = ramaddr;
      end
      @(negedge CLK);
    end
    chk32("fair_dhits", dCnt, ExpDHits);
    chk32("fair_ihits", iCnt, ExpIHits);
    chk32("fair_fifth_grant", fifthAddr, ExpFifth);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
